dsp_biquad_sequencer: RTL and testbench

//  Time-multiplexed controller for a cascade of NSTAGE direct-form-I biquad sections.

---
 rtl/dsp_pkg.sv | 21 ++
 rtl/dsp_biquad_coef_ram.sv | 32 +++
 rtl/dsp_biquad_sequencer.sv | 141 ++++++++++++++
 tb/tb_dsp_biquad_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared types, tap indices and saturation helper for the time-multiplexed biquad cascade.
package dsp_pkg;
  localparam int ACC_W = 40;

  typedef logic signed [15:0]      audio_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, SCALE, DONE} seq_state_e;

  localparam logic [2:0] K_B0 = 3'd0;
  localparam logic [2:0] K_B1 = 3'd1;
  localparam logic [2:0] K_B2 = 3'd2;
  localparam logic [2:0] K_A1 = 3'd3;
  localparam logic [2:0] K_A2 = 3'd4;

  function automatic audio_t sat16(input acc_t a);
    if (a > acc_t'(32767)) return 16'sh7fff;
    if (a < acc_t'(-32768)) return 16'sh8000;
    return a[15:0];
  endfunction
endpackage

// File: rtl/dsp_biquad_coef_ram.sv
// Coefficient store: NSTAGE*5 signed words, sync write, combinational read, resets to pass-through.
module dsp_biquad_coef_ram #(
  parameter int NSTAGE = 4,
  parameter int CW     = 16,
  parameter int DP     = 14,
  parameter int IW     = $clog2(NSTAGE*5)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [IW-1:0]        waddr_i,
  input  logic signed [CW-1:0] wdata_i,
  input  logic [IW-1:0]        raddr_i,
  output logic signed [CW-1:0] rdata_o
);
  localparam int DEPTH = NSTAGE*5;

  logic signed [CW-1:0] mem_q [DEPTH];

  // Word 0 of every stage is B0; unity there and zero elsewhere makes each stage a wire.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i % 5 == 0) ? CW'(1 << DP) : '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/dsp_biquad_sequencer.sv
// Cascade of NSTAGE direct-form-I biquads sharing one MAC, stepped once per iStart strobe.
module dsp_biquad_sequencer
  import dsp_pkg::*;
#(
  parameter int NSTAGE = 4,
  parameter int CW     = 16,
  parameter int DP     = 14,
  parameter int AW     = ACC_W
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iStart,
  input  logic signed [15:0]   iIn,
  output logic signed [15:0]   oOut,
  output logic                 oValid,
  output logic                 oBusy,
  output logic                 oOverrun,
  input  logic                 iCoefWe,
  input  logic [5:0]           iCoefAddr,
  input  logic signed [CW-1:0] iCoefData,
  output logic                 oCoefErr,
  output seq_state_e           oDbgState
);
  localparam int NCOEF = NSTAGE*5;
  localparam int IW    = $clog2(NCOEF);
  localparam int SW    = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  // Handshake: iStart is accepted only in IDLE; oBusy covers LOAD..DONE, where a start is
  // dropped with an oOverrun pulse in that same cycle; oValid is a one-cycle result strobe.
  seq_state_e         state_q;
  logic [SW-1:0]      s_q;
  logic [2:0]         k_q;
  logic signed [AW-1:0] acc_q;
  audio_t             xin_q, out_q;
  logic               valid_q;
  audio_t             x1_q [NSTAGE];
  audio_t             x2_q [NSTAGE];
  audio_t             y1_q [NSTAGE];
  audio_t             y2_q [NSTAGE];

  logic                 busy, addr_ok, ram_we;
  logic [IW-1:0]        rd_addr;
  logic signed [CW-1:0] coef;
  audio_t               opnd, y_d;
  logic signed [AW-1:0] opnd_ext, coef_ext, prod;

  assign busy    = (state_q != IDLE);
  assign addr_ok = (iCoefAddr < 6'(NCOEF));
  assign ram_we  = iCoefWe && !busy && addr_ok;
  assign rd_addr = IW'(32'(s_q) * 5 + 32'(k_q));

  dsp_biquad_coef_ram #(.NSTAGE(NSTAGE), .CW(CW), .DP(DP), .IW(IW)) u_coef (
    .clk_i   (iCLK),
    .rst_ni  (iRST_N),
    .we_i    (ram_we),
    .waddr_i (iCoefAddr[IW-1:0]),
    .wdata_i (iCoefData),
    .raddr_i (rd_addr),
    .rdata_o (coef)
  );

  always_comb begin
    opnd = y2_q[s_q];
    case (k_q)
      K_B0:    opnd = xin_q;
      K_B1:    opnd = x1_q[s_q];
      K_B2:    opnd = x2_q[s_q];
      K_A1:    opnd = y1_q[s_q];
      default: opnd = y2_q[s_q];
    endcase
  end

  assign opnd_ext = {{(AW-16){opnd[15]}}, opnd};
  assign coef_ext = {{(AW-CW){coef[CW-1]}}, coef};
  assign prod     = opnd_ext * coef_ext;
  assign y_d      = sat16(acc_t'(acc_q >>> DP));

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      xin_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < NSTAGE; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (iStart) begin
          xin_q   <= iIn;
          state_q <= LOAD;
        end
        LOAD: begin
          s_q     <= '0;
          k_q     <= '0;
          acc_q   <= '0;
          state_q <= MAC;
        end
        MAC: begin
          acc_q <= (k_q >= K_A1) ? acc_q - prod : acc_q + prod;
          if (k_q == K_A2) state_q <= SCALE;
          else             k_q     <= k_q + 3'd1;
        end
        SCALE: begin
          x2_q[s_q] <= x1_q[s_q];
          x1_q[s_q] <= xin_q;
          y2_q[s_q] <= y1_q[s_q];
          y1_q[s_q] <= y_d;
          xin_q     <= y_d;
          acc_q     <= '0;
          k_q       <= '0;
          // Output registers load here so they are already valid during DONE.
          if (s_q == SW'(NSTAGE-1)) begin
            out_q   <= y_d;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            s_q     <= s_q + 1'b1;
            state_q <= MAC;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oOut      = out_q;
  assign oValid    = valid_q;
  assign oBusy     = busy;
  assign oOverrun  = iRST_N && iStart && busy;
  assign oCoefErr  = iRST_N && iCoefWe && (busy || !addr_ok);
  assign oDbgState = state_q;
endmodule

// File: tb/tb_dsp_biquad_sequencer.sv
// Bench for dsp_biquad_sequencer: vector table, corner-case sequences, random run vs. cascade model.
module tb_dsp_biquad_sequencer;
  import dsp_pkg::*;

  localparam int NST = 4;
  localparam int W   = 16;
  localparam int LAT = NST*6 + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               iRST_N = 1'b0;
  logic               iStart = 1'b0;
  logic signed [15:0] iIn = '0;
  logic               iCoefWe = 1'b0;
  logic [5:0]         iCoefAddr = '0;
  logic signed [15:0] iCoefData = '0;
  logic signed [15:0] oOut;
  logic               oValid, oBusy, oOverrun, oCoefErr;
  seq_state_e         oDbgState;

  dsp_biquad_sequencer #(.NSTAGE(NST)) dut (
    .iCLK(clk), .iRST_N(iRST_N), .iStart(iStart), .iIn(iIn),
    .oOut(oOut), .oValid(oValid), .oBusy(oBusy), .oOverrun(oOverrun),
    .iCoefWe(iCoefWe), .iCoefAddr(iCoefAddr), .iCoefData(iCoefData),
    .oCoefErr(oCoefErr), .oDbgState(oDbgState)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Reference: each stage computes the textbook DF-I equation on plain integers.
  longint m_coef [NST*5];
  longint m_x1 [NST];
  longint m_x2 [NST];
  longint m_y1 [NST];
  longint m_y2 [NST];

  function automatic void model_reset();
    for (int i = 0; i < NST*5; i++) m_coef[i] = (i % 5 == 0) ? 16384 : 0;
    for (int s = 0; s < NST; s++) begin
      m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
    end
  endfunction

  function automatic logic signed [15:0] model_step(input logic signed [15:0] x);
    longint v, acc, y;
    v = x;
    for (int s = 0; s < NST; s++) begin
      acc = m_coef[s*5]*v + m_coef[s*5+1]*m_x1[s] + m_coef[s*5+2]*m_x2[s]
          - m_coef[s*5+3]*m_y1[s] - m_coef[s*5+4]*m_y2[s];
      y = acc >>> 14;
      if (y > 32767) y = 32767;
      else if (y < -32768) y = -32768;
      m_x2[s] = m_x1[s]; m_x1[s] = v;
      m_y2[s] = m_y1[s]; m_y1[s] = y;
      v = y;
    end
    return 16'(v);
  endfunction

  task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 iRST_N = 1'b0;
    @(posedge clk); #1 iRST_N = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  task automatic write_coef(input logic [5:0] addr, input logic signed [15:0] data, input logic exp_err);
    @(posedge clk); #1;
    iCoefWe = 1'b1; iCoefAddr = addr; iCoefData = data;
    @(negedge clk);
    chk("coef_err", oCoefErr, exp_err);
    if (!exp_err) m_coef[addr] = data;
    @(posedge clk); #1 iCoefWe = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!oValid && lat < 100);
  endtask

  task automatic check_result(input string nm);
    logic signed [15:0] e;
    chk({nm, "_valid"}, oValid, 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({nm, "_model"}, oOut, e);
    end else begin
      chk({nm, "_queue"}, 0, 1);
    end
  endtask

  task automatic run_sample(input logic signed [15:0] x, output logic signed [15:0] got);
    int lat;
    @(posedge clk); #1;
    iStart = 1'b1; iIn = x;
    exp_q.push_back(model_step(x));
    @(negedge clk);
    chk("start_overrun", oOverrun, 1'b0);
    @(posedge clk); #1 iStart = 1'b0;
    @(negedge clk);
    chk("busy", oBusy, 1'b1);
    lat = 1;
    while (!oValid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, LAT);
    check_result("sample");
    got = oOut;
  endtask

  typedef struct {
    bit                 rst;
    bit                 we;
    logic [5:0]         addr;
    logic signed [15:0] cdata;
    bit                 smp;
    logic signed [15:0] x;
    logic signed [15:0] exp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] got;
    int lat, nval;

    tbl[0]  = '{1'b1, 1'b0, 6'd0, 16'sd0,     1'b1,  16'sd1000,   16'sd1000};
    tbl[1]  = '{1'b0, 1'b0, 6'd0, 16'sd0,     1'b1,  16'sh8000,   16'sh8000};
    tbl[2]  = '{1'b1, 1'b1, 6'd0, 16'sd0,     1'b0,  16'sd0,      16'sd0};
    tbl[3]  = '{1'b0, 1'b1, 6'd1, 16'sd16384, 1'b1,  16'sd100,    16'sd0};
    tbl[4]  = '{1'b0, 1'b0, 6'd0, 16'sd0,     1'b1,  16'sd200,    16'sd100};
    tbl[5]  = '{1'b0, 1'b0, 6'd0, 16'sd0,     1'b1,  16'sd300,    16'sd200};
    tbl[6]  = '{1'b1, 1'b1, 6'd0, 16'sd32767, 1'b1,  16'sd30000,  16'sd32767};
    tbl[7]  = '{1'b0, 1'b0, 6'd0, 16'sd0,     1'b1, -16'sd30000,  16'sh8000};
    tbl[8]  = '{1'b1, 1'b1, 6'd3, -16'sd8192, 1'b1,  16'sd1000,   16'sd1000};
    tbl[9]  = '{1'b0, 1'b0, 6'd0, 16'sd0,     1'b1,  16'sd0,      16'sd500};
    tbl[10] = '{1'b0, 1'b0, 6'd0, 16'sd0,     1'b1,  16'sd0,      16'sd250};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", oOut, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_overrun", oOverrun, 0);
    chk("rst_coeferr", oCoefErr, 0);
    chk("rst_state", oDbgState, IDLE);
    @(posedge clk); #1 iRST_N = 1'b1;
    model_reset();

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) do_reset();
      if (tbl[i].we) write_coef(tbl[i].addr, tbl[i].cdata, 1'b0);
      if (tbl[i].smp) begin
        run_sample(tbl[i].x, got);
        chk($sformatf("vec%0d", i), got, tbl[i].exp);
      end
    end

    // Overrun at +10, drop in DONE, accept in the following IDLE cycle
    do_reset();
    nval = 0;
    for (int c = 0; c < 58; c++) begin
      @(posedge clk); #1;
      iStart = (c == 0 || c == 10 || c == 26 || c == 27);
      iIn = (c == 0) ? 16'sd1234 : (c == 27) ? -16'sd555 : 16'sd7777;
      if (c == 0)  exp_q.push_back(model_step(16'sd1234));
      if (c == 27) exp_q.push_back(model_step(-16'sd555));
      @(negedge clk);
      if (c == 10 || c == 26 || c == 27)
        chk($sformatf("overrun_c%0d", c), oOverrun, (c != 27));
      if (oValid) begin
        nval++;
        chk("ovr_valid_cycle", c, (nval == 1) ? 26 : 53);
        chk("ovr_out_const", oOut, (nval == 1) ? 1234 : -555);
        check_result("ovr");
      end
    end
    chk("ovr_valid_count", nval, 2);

    // Coefficient write and start in the same idle cycle: the write wins
    do_reset();
    @(posedge clk); #1;
    iCoefWe = 1'b1; iCoefAddr = 6'd0; iCoefData = 16'sd8192;
    iStart = 1'b1; iIn = 16'sd1000;
    m_coef[0] = 8192;
    exp_q.push_back(model_step(16'sd1000));
    @(negedge clk);
    chk("same_cycle_coeferr", oCoefErr, 0);
    @(posedge clk); #1 iCoefWe = 1'b0; iStart = 1'b0;
    wait_valid(lat);
    chk("same_cycle_out", oOut, 500);
    check_result("same_cycle");

    // Coefficient write while busy is dropped; out-of-range write errors
    do_reset();
    @(posedge clk); #1 iStart = 1'b1; iIn = 16'sd2222;
    exp_q.push_back(model_step(16'sd2222));
    @(posedge clk); #1 iStart = 1'b0;
    repeat (3) @(posedge clk);
    #1 iCoefWe = 1'b1; iCoefAddr = 6'd0; iCoefData = 16'sd0;
    @(negedge clk);
    chk("coef_busy_err", oCoefErr, 1);
    @(posedge clk); #1 iCoefWe = 1'b0;
    wait_valid(lat);
    chk("busy_write_out", oOut, 2222);
    check_result("busy_write");
    run_sample(-16'sd1234, got);
    chk("coef_unchanged", got, -1234);
    write_coef(6'd20, 16'sd5, 1'b1);
    write_coef(6'd19, 16'sd0, 1'b0);
    run_sample(16'sd55, got);

    // Reset in the middle of a sample
    @(posedge clk); #1 iStart = 1'b1; iIn = 16'sd4321;
    @(posedge clk); #1 iStart = 1'b0;
    repeat (11) @(posedge clk);
    #1 iRST_N = 1'b0;
    @(posedge clk); #1 iRST_N = 1'b1;
    model_reset();
    exp_q.delete();
    nval = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (oValid) nval++;
    end
    chk("midrst_no_valid", nval, 0);
    chk("midrst_out", oOut, 0);
    chk("midrst_busy", oBusy, 0);
    run_sample(16'sd777, got);
    chk("midrst_passthru", got, 777);

    // Random coefficients and samples against the model
    do_reset();
    for (int g = 0; g < 4; g++) begin
      for (int w = 0; w < 4; w++)
        write_coef(6'($urandom_range(0, 19)), 16'(int'($urandom_range(0, 32767)) - 16384), 1'b0);
      for (int n = 0; n < 8; n++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        run_sample(16'($urandom_range(0, 65535)), got);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
